riscv_fetch_queue: RTL and testbench

Instruction-fetch stage for the Advanced RISC-V pipeline. It owns the fetch PC, issues single-outstanding requests to instruction memory, and buffers returned words in a DEPTH-entry FIFO. It presents them in order to the decode stage over a valid/ready handshake. Branch/jump redirects from EX flush the queue and any in-flight fetch.

---
 rtl/riscv_fetch_queue.sv | 137 +++++++++++++
 tb/tb_riscv_fetch_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_queue.sv
// rtl/riscv_fetch_queue.sv - fetch PC, single-outstanding imem request and in-order fetch FIFO.
// Build option IFQ_BYPASS_EN: an acknowledged word reaches decode in the same cycle when the queue is empty.
module riscv_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    imem_req,
    output logic [XLEN-1:0]         imem_addr,
    input  logic                    imem_ack,
    input  logic [31:0]             imem_rdata,
    input  logic                    redirect_valid,
    input  logic [XLEN-1:0]         redirect_pc,
    output logic                    id_valid,
    input  logic                    id_ready,
    output logic [31:0]             id_instr,
    output logic [XLEN-1:0]         id_pc,
    output logic [$clog2(DEPTH):0]  q_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {FETCH, DROP} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
    logic [XLEN-1:0] saved_pc, saved_pc_nxt;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     mem_instr [DEPTH];
    logic [XLEN-1:0] mem_pc    [DEPTH];

    logic            q_valid;
    logic            push, pop, flush;
    logic [XLEN-1:0] target;

    assign q_valid  = (count != '0);
    assign target   = redirect_pc & ~XLEN'(3);
    // fetch_pc is left untouched on entry to DROP, so it is still the pending address
    assign imem_addr = fetch_pc;
    assign imem_req  = rst && ((state == DROP) || (count < CW'(DEPTH)));

`ifdef IFQ_BYPASS_EN
    logic byp;
    assign byp      = rst && (state == FETCH) && !q_valid && imem_ack && !redirect_valid;
    assign id_valid = q_valid || byp;
    assign id_instr = q_valid ? mem_instr[rd_ptr] : (byp ? imem_rdata : '0);
    assign id_pc    = q_valid ? mem_pc[rd_ptr]    : (byp ? fetch_pc   : '0);
`else
    assign id_valid = q_valid;
    assign id_instr = q_valid ? mem_instr[rd_ptr] : '0;
    assign id_pc    = q_valid ? mem_pc[rd_ptr]    : '0;
`endif
    assign q_count  = count;

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        saved_pc_nxt = saved_pc;
        push         = 1'b0;
        pop          = 1'b0;
        flush        = 1'b0;
        if (redirect_valid) begin
            flush = 1'b1;
            if (state == FETCH) begin
                if (imem_req && !imem_ack) begin
                    saved_pc_nxt = target;
                    state_nxt    = DROP;
                end else begin
                    fetch_pc_nxt = target;
                end
            end else begin
                saved_pc_nxt = target;
                if (imem_ack) begin
                    state_nxt    = FETCH;
                    fetch_pc_nxt = target;
                end
            end
        end else begin
            pop = q_valid && id_ready;
            if (state == FETCH) begin
                if (imem_req && imem_ack) begin
                    push         = 1'b1;
                    fetch_pc_nxt = fetch_pc + XLEN'(4);
                end
            end else if (imem_ack) begin
                state_nxt    = FETCH;
                fetch_pc_nxt = saved_pc;
            end
        end
`ifdef IFQ_BYPASS_EN
        // word consumed directly by decode never occupies a queue slot
        if (byp && id_ready) begin
            push = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            saved_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            saved_pc <= saved_pc_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr]    <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// tb/tb_riscv_fetch_queue.sv - self-checking bench for riscv_fetch_queue with a queue-level reference model.
module tb_riscv_fetch_queue;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [1:0]  q_count;

    int n_vec = 0;
    int n_err = 0;

    bit ack_tied;
    int mem_wait;
    int wait_cnt = 0;

    riscv_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .q_count(q_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // instruction memory: ack either tied high or after mem_wait cycles of a held request
    assign imem_ack   = ack_tied ? 1'b1 : (imem_req && (wait_cnt >= mem_wait));
    assign imem_rdata = imem_ack ? instr_of(imem_addr) : 32'hDEAD_BEEF;

    always @(posedge clk) wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_saved = RESET_PC;
    logic [31:0] m_drop_addr = RESET_PC;
    bit          m_drop = 1'b0;

    always @(negedge clk) begin : model
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] tgt;
        if (!rst) begin
            mq.delete();
            m_pc   = RESET_PC;
            m_drop = 1'b0;
        end
        e_req  = rst && (m_drop || (mq.size() < DEPTH));
        e_addr = m_drop ? m_drop_addr : m_pc;
        chk("m_req",   32'(imem_req), 32'(e_req));
        chk("m_addr",  imem_addr, e_addr);
        chk("m_valid", 32'(id_valid), 32'(mq.size() != 0));
        chk("m_count", 32'(q_count), 32'(mq.size()));
        if (!rst) begin
            chk("m_rst_instr", id_instr, 32'h0);
            chk("m_rst_pc",    id_pc,    32'h0);
        end else if (mq.size() != 0) begin
            chk("m_instr", id_instr, mq[0].ins);
            chk("m_pc",    id_pc,    mq[0].pc);
        end
        if (rst) begin
            if (redirect_valid) begin
                tgt = {redirect_pc[31:2], 2'b00};
                mq.delete();
                if (!m_drop) begin
                    if (e_req && !imem_ack) begin
                        m_drop      = 1'b1;
                        m_drop_addr = m_pc;
                        m_saved     = tgt;
                    end else begin
                        m_pc = tgt;
                    end
                end else begin
                    m_saved = tgt;
                    if (imem_ack) begin
                        m_drop = 1'b0;
                        m_pc   = tgt;
                    end
                end
            end else begin
                if (mq.size() != 0 && id_ready) void'(mq.pop_front());
                if (!m_drop) begin
                    if (e_req && imem_ack) begin
                        mq.push_back('{pc: m_pc, ins: instr_of(m_pc)});
                        m_pc = m_pc + 32'd4;
                    end
                end else if (imem_ack) begin
                    m_drop = 1'b0;
                    m_pc   = m_saved;
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish, n_err=%0d", n_err);
        $fatal(1);
    end

    initial begin
        bit found;
        rst = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        ack_tied = 1'b1; mem_wait = 0;

        // reset, then zero-wait streaming
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("a_rst_req",   32'(imem_req), 32'h0);
        chk("a_rst_addr",  imem_addr, 32'h0);
        chk("a_rst_valid", 32'(id_valid), 32'h0);
        chk("a_rst_count", 32'(q_count), 32'h0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("a_first_gap", 32'(id_valid), 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("a_stream_valid", 32'(id_valid), 32'h1);
            chk("a_stream_pc",    id_pc, 32'(4 * k));
        end

        // decode stall from reset: queue fills, request stops, then drains in order
        @(posedge clk); #1 rst = 1'b0; id_ready = 1'b0;
        #1;
        chk("b_async_req",   32'(imem_req), 32'h0);
        chk("b_async_valid", 32'(id_valid), 32'h0);
        repeat (2) @(posedge clk); #1 rst = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("b_full_count", 32'(q_count), 32'h2);
        chk("b_full_req",   32'(imem_req), 32'h0);
        chk("b_full_addr",  imem_addr, 32'h8);
        @(posedge clk); #1 id_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("b_drain_pc", id_pc, 32'(4 * k));
        end

        // redirect while a slow fetch is pending
        @(posedge clk); #1 rst = 1'b0; ack_tied = 1'b0; mem_wait = 3;
        repeat (2) @(posedge clk); #1 rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0101;
        @(posedge clk); #1 redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("c_hold_req",   32'(imem_req), 32'h1);
            chk("c_hold_addr",  imem_addr, 32'h0);
            chk("c_drop_valid", 32'(id_valid), 32'h0);
        end
        @(negedge clk);
        chk("c_new_addr", imem_addr, 32'h100);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (id_valid) found = 1'b1;
        end
        chk("c_first_valid", 32'(found), 32'h1);
        chk("c_first_pc",    id_pc, 32'h100);

        // redirect coinciding with a pop on a full queue
        @(posedge clk); #1 rst = 1'b0; ack_tied = 1'b1; id_ready = 1'b0;
        repeat (2) @(posedge clk); #1 rst = 1'b1;
        repeat (4) @(posedge clk); #1 id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        chk("d_pre_count", 32'(q_count), 32'h2);
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(negedge clk);
        chk("d_flush_valid", 32'(id_valid), 32'h0);
        chk("d_flush_count", 32'(q_count), 32'h0);
        @(negedge clk);
        chk("d_next_valid", 32'(id_valid), 32'h1);
        chk("d_next_pc",    id_pc, 32'h200);

        // fetch PC wraps at the top of the address space
        @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(negedge clk);
        chk("e_top_addr", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("e_wrap_addr", imem_addr, 32'h0);
        chk("e_top_pc",    id_pc, 32'hFFFF_FFFC);

        // reset asserted while dropping a stale fetch
        @(posedge clk); #1 ack_tied = 1'b0; mem_wait = 3; redirect_valid = 1'b1; redirect_pc = 32'h300;
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        #1;
        chk("f_rst_req",   32'(imem_req), 32'h0);
        chk("f_rst_addr",  imem_addr, RESET_PC);
        chk("f_rst_valid", 32'(id_valid), 32'h0);
        chk("f_rst_count", 32'(q_count), 32'h0);
        chk("f_rst_instr", id_instr, 32'h0);
        ack_tied = 1'b1;
        repeat (2) @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("f_restart_req",  32'(imem_req), 32'h1);
        chk("f_restart_addr", imem_addr, RESET_PC);
        @(negedge clk);
        chk("f_first_valid", 32'(id_valid), 32'h1);
        chk("f_first_pc",    id_pc, RESET_PC);

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
